// File: rtl/data_mem_resp.sv
// data_mem_resp: single-outstanding data memory responder.
// A request handshake captures the command, a programmable wait of RD_LAT
// cycles models the array access time, and the response is held until the
// initiator takes it. Word addresses at or above DEPTH return an error.
// Optional build macro: DMEM_RESET_INIT_EN -- when defined, reset loads
// mem[i] = i; when undefined, reset leaves the array contents alone.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a new request (req_ready_o high when out of reset)
// S_ACCESS | request captured, wait counter running toward the access edge
// S_RESP   | response valid, held until rsp_ready_i
module data_mem_resp #(
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_we_i,
  input  logic [4:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  output logic       busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [4:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           access_fire;
  logic           in_range;
  logic           mem_we;
  logic [7:0]     mem_rd;
  logic [AW-1:0]  mem_idx;
  logic [7:0]     mem_q [DEPTH];

  assign in_range = ({1'b0, addr_q} < 6'(DEPTH));
  assign mem_idx  = addr_q[AW-1:0];
  // Writes only happen on the access edge of an in-range store, never in reset.
  assign mem_we   = access_fire && we_q && in_range && !rst_i;

  // Array read port; out-of-range addresses never index the array.
  always_comb begin
    mem_rd = 8'h00;
    if (in_range) begin
      mem_rd = mem_q[mem_idx];
    end
  end

  // Next-state and response-capture logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    access_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_ACCESS;
          cnt_d   = 4'(RD_LAT - 1);
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          access_fire = 1'b1;
          state_d     = S_RESP;
          err_d       = !in_range;
          rdata_d     = (!we_q && in_range) ? mem_rd : 8'h00;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Completion edge: no accept here, so back-to-back spacing is RD_LAT+2.
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = 8'h00;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_RESET_INIT_EN
  // Storage array, preloaded with its own word index on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'(i);
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end
`else
  // Storage array; contents survive reset and are undefined at power-up.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end
`endif

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Testbench for data_mem_resp: directed requests, a transaction-level
// reference model and a per-cycle output comparator.
module tb_data_mem_resp;

  localparam int DEPTH  = 24;
  localparam int RD_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  data_mem_resp #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected response at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem_m   [32];
  bit         known_m [32];
  bit         pending = 0;
  int         edges   = 0;
  bit         m_we;
  logic [4:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  bit         m_err;
  bit         m_known;
  bit         started = 0;
  bit         b2b = 0;
  longint     last_acc_t = -1;
  int         acc_cnt = 0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_m[i]   = 8'h00;
      known_m[i] = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending = 0;
      edges   = 0;
`ifdef DMEM_RESET_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[i]   = 8'(i);
        known_m[i] = 1;
      end
`endif
    end else if (pending) begin
      if (edges >= RD_LAT) begin
        if (rsp_ready) pending = 0;
      end else begin
        edges++;
        if (edges == RD_LAT && m_we && !m_err) begin
          mem_m[m_addr]   = m_wdata;
          known_m[m_addr] = 1;
        end
      end
    end else if (req_valid) begin
      pending = 1;
      edges   = 0;
      m_we    = req_we;
      m_addr  = req_addr;
      m_wdata = req_wdata;
      m_err   = (int'(req_addr) >= DEPTH);
      m_rdata = (!req_we && !m_err) ? mem_m[req_addr] : 8'h00;
      m_known = req_we || m_err || known_m[req_addr];
      if (b2b) begin
        acc_cnt++;
        if (last_acc_t >= 0) chk("b2b_spacing", 32'(($time - last_acc_t) / 10), RD_LAT + 2);
        last_acc_t = $time;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      bit exp_v;
      exp_v = pending && (edges >= RD_LAT);
      chk("req_ready", req_ready, (!pending && !rst));
      chk("busy", busy, pending);
      chk("rsp_valid", rsp_valid, exp_v);
      if (rst) begin
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_err", rsp_err, 1'b0);
      end else if (exp_v) begin
        chk("rsp_err", rsp_err, m_err);
        if (m_known) chk("rsp_rdata", rsp_rdata, m_rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic we, input logic [4:0] a, input logic [7:0] d,
                        input int hold, output logic [7:0] rd, output logic er,
                        output int lat);
    int n;
    rd = 8'h00;
    er = 1'b0;
    lat = -1;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = ~a;
    req_wdata = ~d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 50);
    if (!rsp_valid) begin
      fail_now("rsp_timeout");
      rsp_ready = 1'b1;
      return;
    end
    lat = n;
    rd = rsp_rdata;
    er = rsp_err;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      chk("hold_rdata", rsp_rdata, rd);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rsp_fall", rsp_valid, 1'b0);
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b_we   [6];
    logic [4:0]  b_addr [6];
    logic [7:0]  b_data [6];
    int          n;

    started = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset_ready", req_ready, 1'b0);
    chk("in_reset_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);

    do_req(1'b1, 5'd5, 8'hA5, 0, rd, er, lat);
    chk("st5_lat", lat, 2);
    chk("st5_rdata", rd, 8'h00);
    chk("st5_err", er, 1'b0);
    do_req(1'b0, 5'd5, 8'h00, 0, rd, er, lat);
    chk("ld5_lat", lat, 2);
    chk("ld5_rdata", rd, 8'hA5);
    chk("ld5_err", er, 1'b0);

    do_req(1'b1, 5'd18, 8'h5E, 0, rd, er, lat);
    do_req(1'b1, 5'd6,  8'h66, 0, rd, er, lat);
    do_req(1'b1, 5'd14, 8'hE4, 0, rd, er, lat);
    do_req(1'b1, 5'd3,  8'hC3, 0, rd, er, lat);
    do_req(1'b1, 5'd7,  8'h11, 0, rd, er, lat);

    do_req(1'b1, 5'd30, 8'hFF, 0, rd, er, lat);
    chk("st30_err", er, 1'b1);
    chk("st30_rdata", rd, 8'h00);
    do_req(1'b0, 5'd30, 8'h00, 0, rd, er, lat);
    chk("ld30_err", er, 1'b1);
    chk("ld30_rdata", rd, 8'h00);
    do_req(1'b0, 5'd6, 8'h00, 0, rd, er, lat);
    chk("ld6_untouched", rd, 8'h66);
    do_req(1'b0, 5'd14, 8'h00, 0, rd, er, lat);
    chk("ld14_untouched", rd, 8'hE4);

    do_req(1'b0, 5'd3, 8'h00, 5, rd, er, lat);
    chk("ld3_hold_rdata", rd, 8'hC3);
    chk("ld3_hold_lat", lat, 2);

    // Store to 7 aborted by a reset one cycle after accept.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 5'd7;
    req_wdata = 8'h3C;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now("abort_accept_timeout");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", req_ready, 1'b0);
    chk("abort_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b0, 5'd7, 8'h00, 0, rd, er, lat);
`ifdef DMEM_RESET_INIT_EN
    chk("ld7_after_abort", rd, 8'h07);
`else
    chk("ld7_after_abort", rd, 8'h11);
`endif
    do_req(1'b0, 5'd18, 8'h00, 0, rd, er, lat);
`ifdef DMEM_RESET_INIT_EN
    chk("ld18_after_rst", rd, 8'h12);
`else
    chk("ld18_after_rst", rd, 8'h5E);
`endif

    // Back-to-back with req_valid held high.
    b_we[0] = 1'b1; b_addr[0] = 5'd1; b_data[0] = 8'h10;
    b_we[1] = 1'b1; b_addr[1] = 5'd2; b_data[1] = 8'h20;
    b_we[2] = 1'b0; b_addr[2] = 5'd1; b_data[2] = 8'h00;
    b_we[3] = 1'b0; b_addr[3] = 5'd2; b_data[3] = 8'h00;
    b_we[4] = 1'b1; b_addr[4] = 5'd1; b_data[4] = 8'h33;
    b_we[5] = 1'b0; b_addr[5] = 5'd1; b_data[5] = 8'h00;
    b2b = 1;
    last_acc_t = -1;
    acc_cnt = 0;
    rsp_ready = 1'b1;
    req_we = b_we[0];
    req_addr = b_addr[0];
    req_wdata = b_data[0];
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!req_ready) begin
        fail_now("b2b_accept_timeout");
        break;
      end
      @(posedge clk);
      #1;
      if (i < 5) begin
        req_we = b_we[i+1];
        req_addr = b_addr[i+1];
        req_wdata = b_data[i+1];
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    chk("b2b_accepts", acc_cnt, 6);
    chk("b2b_idle", busy, 1'b0);
    b2b = 0;

    do_req(1'b0, 5'd2, 8'h00, 0, rd, er, lat);
    chk("ld2_b2b", rd, 8'h20);
    do_req(1'b0, 5'd1, 8'h00, 0, rd, er, lat);
    chk("ld1_b2b", rd, 8'h33);

    @(negedge clk);
    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
